// File: rtl/frame_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pingpong_buffer
//  Description : Two-bank ping-pong sample store between the ADC stream and
//                the FFT. One bank fills with decimated samples while the
//                other bank is read at random addresses. The banks swap under
//                a frame_ready / frame_done handshake, and dropped samples
//                raise a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_pingpong_buffer #(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 11,
  parameter int DEC_W  = 4,
  parameter int FC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic [DEC_W-1:0]  decim,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              frame_ready,
  input  logic              frame_done,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [FC_W-1:0]   frame_count
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // Both banks share one array; the bank select is the top address bit.
  logic [WIDTH-1:0]  mem [0:2*DEPTH-1];

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        bank_full;
  logic [1:0]        bank_full_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DEC_W-1:0]  dec_cnt;

  logic              keep;
  logic              wr_en;
  logic              drop;
  logic              frame_end;
  logic              rd_release;

  // A sample is kept only on the first of every decim+1 valid samples.
  assign keep        = in_valid && (dec_cnt == '0);
  assign in_ready    = !bank_full[wr_bank];
  assign frame_ready = bank_full[rd_bank];
  assign wr_en       = keep && in_ready;
  assign drop        = keep && !in_ready;
  assign frame_end   = wr_en && (wr_ptr == LAST_ADDR);
  assign rd_release  = frame_done && frame_ready;

  // Fill completion and release always touch different banks (one is empty,
  // the other full), so both updates apply in the same cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (frame_end) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rd_release) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  // Bank bookkeeping, write pointer, decimation phase and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      bank_full   <= 2'b00;
      wr_ptr      <= '0;
      dec_cnt     <= '0;
      frame_count <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (in_valid) begin
        // Comparing against the live decim lets a smaller ratio cut the
        // current phase short instead of waiting for the old wrap.
        dec_cnt <= (dec_cnt >= decim) ? '0 : dec_cnt + DEC_W'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (frame_end) begin
        wr_bank     <= !wr_bank;
        frame_count <= frame_count + FC_W'(1);
      end
      if (rd_release) begin
        rd_bank <= !rd_bank;
      end
    end
  end

  // Sticky overflow; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Sample memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[{wr_bank, wr_ptr}] <= in_data;
    end
  end

  // Registered read port; output holds when no request is made.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule
`default_nettype wire
